// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches two endpoints and streams one pixel per accepted cycle.
// Screen clipping is optional and enabled by defining LINE_DRAWER_CLIP_EN.
module line_drawer (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [8:0] i_x0,
    input  logic [8:0] i_x1,
    input  logic [7:0] i_y0,
    input  logic [7:0] i_y1,
    input  logic [2:0] i_color,
    input  logic       i_ready,
    output logic       o_plot,
    output logic [8:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_color,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Endpoints as latched from the ports
    logic [8:0] lx0, lx1;
    logic [7:0] ly0, ly1;
    logic [2:0] color;

    // Walk state: x is always the major axis after the steep swap
    logic              steep;
    logic              ystep_neg;
    logic [8:0]        x, y, x_end;
    logic [8:0]        dx, dy;
    logic signed [10:0] err;

    // INIT-cycle setup, derived from the latched endpoints
    logic [8:0] adx, ady;
    logic       init_steep;
    logic [8:0] ax0, ay0, ax1, ay1;
    logic [8:0] sx0, sy0, sx1, sy1;
    logic [8:0] init_dx, init_dy;
    logic       init_ystep_neg;
    logic signed [10:0] init_err;

    always_comb begin
        adx        = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
        ady        = {1'b0, (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1)};
        init_steep = (ady > adx);

        ax0 = init_steep ? {1'b0, ly0} : lx0;
        ay0 = init_steep ? lx0 : {1'b0, ly0};
        ax1 = init_steep ? {1'b0, ly1} : lx1;
        ay1 = init_steep ? lx1 : {1'b0, ly1};

        if (ax0 > ax1) begin
            sx0 = ax1;
            sy0 = ay1;
            sx1 = ax0;
            sy1 = ay0;
        end else begin
            sx0 = ax0;
            sy0 = ay0;
            sx1 = ax1;
            sy1 = ay1;
        end

        init_dx        = sx1 - sx0;
        init_dy        = (sy1 >= sy0) ? (sy1 - sy0) : (sy0 - sy1);
        init_ystep_neg = !(sy0 < sy1);
        init_err       = -$signed({3'b000, init_dx[8:1]});
    end

    // Screen-space pixel and the accept condition
    logic [8:0]         px;
    logic [7:0]         py;
    logic               offscreen;
    logic               consume;
    logic signed [10:0] err_sum;

    always_comb begin
        px = steep ? y : x;
        py = steep ? x[7:0] : y[7:0];
`ifdef LINE_DRAWER_CLIP_EN
        offscreen = (px >= 9'd336) || (py >= 8'd210);
`else
        offscreen = 1'b0;
`endif
        consume = (state == DRAW) && (i_ready || offscreen);
        err_sum = err + $signed({2'b00, dy});
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        o_plot    = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                state_nxt = DRAW;
            end
            DRAW: begin
                o_plot = !offscreen;
                if (consume && (x == x_end)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lx0       <= '0;
            lx1       <= '0;
            ly0       <= '0;
            ly1       <= '0;
            color     <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
            x         <= '0;
            y         <= '0;
            x_end     <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        lx0   <= i_x0;
                        lx1   <= i_x1;
                        ly0   <= i_y0;
                        ly1   <= i_y1;
                        color <= i_color;
                    end
                end
                INIT: begin
                    steep     <= init_steep;
                    ystep_neg <= init_ystep_neg;
                    x         <= sx0;
                    y         <= sy0;
                    x_end     <= sx1;
                    dx        <= init_dx;
                    dy        <= init_dy;
                    err       <= init_err;
                end
                DRAW: begin
                    if (consume && (x != x_end)) begin
                        x <= x + 9'd1;
                        if (err_sum > 11'sd0) begin
                            y   <= ystep_neg ? (y - 9'd1) : (y + 9'd1);
                            err <= err_sum - $signed({2'b00, dx});
                        end else begin
                            err <= err_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_x     = px;
    assign o_y     = py;
    assign o_color = color;

endmodule

// File: tb/tb_line_drawer.sv
// Randomised and directed bench for line_drawer against an integer reference rasteriser.
module tb_line_drawer;

    logic       clk = 1'b0;
    logic       i_reset, i_start, i_ready;
    logic [8:0] i_x0, i_x1;
    logic [7:0] i_y0, i_y1;
    logic [2:0] i_color;
    logic       o_plot, o_busy, o_done;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_color;

    always #5 clk = ~clk;

    line_drawer dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_x0    (i_x0),
        .i_x1    (i_x1),
        .i_y0    (i_y0),
        .i_y1    (i_y1),
        .i_color (i_color),
        .i_ready (i_ready),
        .o_plot  (o_plot),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_color (o_color),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    int errors = 0;
    int checks = 0;
    int qx[$];
    int qy[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal pixel list in screen coordinates, ordered along the major axis
    function automatic void model(int ax0, int ay0, int ax1, int ay1);
        int x0, y0, x1, y1, t, ddx, ddy, e, ys, yy;
        bit st;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        qx.delete();
        qy.delete();
        st = ((y1 > y0 ? y1 - y0 : y0 - y1) > (x1 > x0 ? x1 - x0 : x0 - x1));
        if (st) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        ddx = x1 - x0;
        ddy = (y1 > y0) ? y1 - y0 : y0 - y1;
        e   = -(ddx / 2);
        ys  = (y0 < y1) ? 1 : -1;
        yy  = y0;
        for (int xx = x0; xx <= x1; xx++) begin
            qx.push_back(st ? yy : xx);
            qy.push_back(st ? xx : yy);
            e = e + ddy;
            if (e > 0) begin
                yy = yy + ys;
                e  = e - ddx;
            end
        end
    endfunction

    function automatic bit clipped(int x, int y);
`ifdef LINE_DRAWER_CLIP_EN
        return (x >= 336) || (y >= 210);
`else
        return (x < 0) && (y < 0);
`endif
    endfunction

    task automatic pin(string name, int ex0, int ex1, int ex2, int ex3, int ey0, int ey1, int ey2, int ey3);
        int ex[4];
        int ey[4];
        ex = '{ex0, ex1, ex2, ex3};
        ey = '{ey0, ey1, ey2, ey3};
        check({name, "_len"}, qx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check({name, "_x"}, qx[i], ex[i]);
            check({name, "_y"}, qy[i], ey[i]);
        end
    endtask

    task automatic run_line(int x0, int y0, int x1, int y1, int col,
                            int stall_at, int stall_len, bit rnd_ready, bit noise);
        int  n, p, c, bound;
        bit  rdy, exp_plot;
        model(x0, y0, x1, y1);
        n     = qx.size();
        bound = 4 * n + 40;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_x0 = 9'(x0); i_y0 = 8'(y0); i_x1 = 9'(x1); i_y1 = 8'(y1);
        i_color = 3'(col);
        @(posedge clk); #1;
        i_start = 1'b0;
        if (noise) begin
            i_x0 = 9'($urandom); i_x1 = 9'($urandom); i_color = 3'($urandom);
        end
        @(negedge clk);
        check("init_busy", o_busy, 1);
        check("init_plot", o_plot, 0);
        @(posedge clk);
        p = 0;
        for (c = 0; c < bound; c++) begin
            #1;
            if (rnd_ready) rdy = ($urandom_range(2, 0) != 0);
            else           rdy = !(c >= stall_at && c < stall_at + stall_len);
            i_ready = rdy;
            if (noise) begin
                i_start = 1'($urandom);
                i_x0 = 9'($urandom); i_y1 = 8'($urandom); i_color = 3'($urandom);
            end
            @(negedge clk);
            exp_plot = (p < n) && !clipped(qx[p], qy[p]);
            check("plot", o_plot, exp_plot);
            if (exp_plot) begin
                check("pix_x", o_x, qx[p]);
                check("pix_y", o_y, qy[p]);
                check("pix_color", o_color, col);
            end
            check("done", o_done, (p == n));
            check("busy", o_busy, 1);
            if (p == n) break;
            if (rdy || clipped(qx[p], qy[p])) p++;
            @(posedge clk);
        end
        if (c >= bound) begin
            errors++;
            $display("FAIL timeout: no done after %0d cycles, expected within %0d", c, bound);
            i_reset = 1'b1;
            @(posedge clk); #1;
            i_reset = 1'b0;
        end else begin
            if (!rnd_ready && (stall_len == 0 || !clipped(qx[stall_at], qy[stall_at])))
                check("done_cycle", c, n + stall_len);
            @(posedge clk); #1;
            i_start = 1'b0;
            i_ready = 1'b1;
            @(negedge clk);
            check("idle_busy", o_busy, 0);
            check("idle_plot", o_plot, 0);
            check("idle_done", o_done, 0);
        end
    endtask

    task automatic check_all_zero(string name);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_plot"}, o_plot, 0);
        check({name, "_done"}, o_done, 0);
        check({name, "_x"}, o_x, 0);
        check({name, "_y"}, o_y, 0);
        check({name, "_color"}, o_color, 0);
    endtask

    initial begin
        int vis;
        i_reset = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0; i_color = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 i_reset = 1'b0;

        // Hand-derived pixel sequences pin the reference model
        model(0, 0, 3, 0); pin("pin_horiz", 0, 1, 2, 3, 0, 0, 0, 0);
        model(0, 0, 1, 3); pin("pin_steep", 0, 0, 1, 1, 0, 1, 2, 3);
        model(3, 2, 0, 2); pin("pin_rev",   0, 1, 2, 3, 2, 2, 2, 2);
        model(334, 0, 337, 0);
        vis = 0;
        foreach (qx[i]) if (!clipped(qx[i], qy[i])) vis++;
`ifdef LINE_DRAWER_CLIP_EN
        check("pin_clip_count", vis, 2);
`else
        check("pin_clip_count", vis, 4);
`endif

        run_line(0, 0, 3, 0, 5, 0, 0, 0, 0);
        run_line(0, 0, 1, 3, 2, 0, 0, 0, 0);
        run_line(3, 2, 0, 2, 7, 0, 0, 0, 0);
        run_line(0, 0, 3, 0, 3, 1, 3, 0, 0);
        run_line(7, 9, 7, 9, 6, 0, 0, 0, 0);
        run_line(334, 0, 337, 0, 4, 0, 0, 0, 0);
        run_line(0, 255, 511, 0, 1, 0, 0, 0, 0);
        run_line(511, 255, 0, 0, 2, 5, 4, 0, 1);
        run_line(100, 250, 105, 0, 3, 0, 0, 0, 0);

        // Reset in the middle of the second pixel
        @(posedge clk); #1;
        i_start = 1'b1; i_x0 = 0; i_y0 = 0; i_x1 = 5; i_y1 = 5; i_color = 3'd6;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_plot", o_plot, 1);
        check("mid_x", o_x, 1);
        check("mid_y", o_y, 1);
        i_reset = 1'b1;
        @(posedge clk); #1 i_reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        run_line(0, 0, 5, 5, 6, 0, 0, 0, 0);

        // Reset wins over a simultaneous start
        @(posedge clk); #1;
        i_reset = 1'b1; i_start = 1'b1; i_x0 = 9; i_x1 = 20; i_y0 = 3; i_y1 = 4; i_color = 3'd7;
        @(posedge clk); #1;
        i_reset = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check_all_zero("rst_prio");

        for (int k = 0; k < 20; k++) begin
            run_line($urandom_range(511, 0), $urandom_range(255, 0),
                     $urandom_range(511, 0), $urandom_range(255, 0),
                     $urandom_range(7, 0), 0, 0, 1, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
